// File: rtl/apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_arbiter_if
//   Bundles the requester handshakes and the APB slave signals of
//   apb_arbiter. Signal names match the original flat port list.
//
//   Requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  (in)
//                    ack0/ack1, err, rdata                           (out)
//   APB side       : paddr, pwrite, psel, penable, pwdata            (out)
//                    valid, prdata                                   (in)
//
//   modport master : view taken by the arbiter
//   modport slave  : opposite view (requesters + APB memory slave)
// -----------------------------------------------------------------------------
interface apb_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // requester port 0 (instruction fetch) and port 1 (load/store)
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic              err;
   logic [DATA_W-1:0] rdata;

   // APB towards the memory slave
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [DATA_W-1:0] pwdata;
   logic              valid;
   logic [DATA_W-1:0] prdata;

   modport master (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  valid, prdata,
      output ack0, ack1, err, rdata,
      output paddr, pwrite, psel, penable, pwdata
   );

   modport slave (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output valid, prdata,
      input  ack0, ack1, err, rdata,
      input  paddr, pwrite, psel, penable, pwdata
   );
endinterface

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
//   Two-port APB master sharing one APB memory slave between the
//   instruction-fetch port (port 0) and the load/store port (port 1).
//   Each port issues a req/ack transfer; the winner is registered onto the
//   APB bus, SETUP/ACCESS are sequenced, reads wait in RDWAIT for the
//   slave's valid and give up after TIMEOUT cycles with err=1, rdata='1.
//
//   Ports:
//     clk  - clock, all logic on posedge
//     rst  - asynchronous, active-high reset
//     bus  - apb_arbiter_if.master (requester handshakes + APB signals)
//
//   Parameters:
//     ADDR_W  - address width
//     DATA_W  - data width
//     TIMEOUT - max cycles in RDWAIT before an error ack (1..15)
//
//   Build option:
//     APB_ARB_RR_EN - defined: round-robin between the two ports on a tie.
//                     undefined: fixed priority, port 1 beats port 0.
// -----------------------------------------------------------------------------
module apb_arbiter #(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter int unsigned TIMEOUT = 4
) (
   input  logic          clk,
   input  logic          rst,
   apb_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RDWAIT = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic              grant_q;     // port currently being served
   logic [3:0]        cnt_q;       // RDWAIT cycles spent without valid

   logic              ack0_q;
   logic              ack1_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;

   logic              psel_c;
   logic              penable_c;

   logic              elig0;
   logic              elig1;
   logic              win;         // 0 = port 0, 1 = port 1
   logic              start;
   logic              timeout_hit;

   // A port whose ack is high this cycle sits out one cycle, so a held req
   // is only seen as a new request from the following cycle.
   assign elig0 = bus.req0 & ~ack0_q;
   assign elig1 = bus.req1 & ~ack1_q;
   assign start = (state_q == IDLE) & (elig0 | elig1);

   // Counter is compared one short of TIMEOUT because the ack is registered:
   // the last RDWAIT cycle is the one in which the counter reads TIMEOUT-1.
   assign timeout_hit = (cnt_q == 4'(TIMEOUT - 1));

`ifdef APB_ARB_RR_EN
   logic last_q;                   // port granted most recently

   always_comb begin
      if (elig0 & elig1) begin
         win = ~last_q;
      end else begin
         win = elig1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (start) begin
         last_q <= win;
      end
   end
`else
   // Fixed priority: port 1 wins whenever it is eligible.
   always_comb begin
      win = elig1;
   end
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and APB strobes. Strobes decode straight from the
   // state so an asynchronous reset drops them immediately.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      psel_c    = 1'b0;
      penable_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            psel_c  = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel_c    = 1'b1;
            penable_c = 1'b1;
            state_d   = pwrite_q ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            if (bus.valid || timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: grant capture, timeout counter, ack/err/rdata generation
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q  <= 1'b0;
         cnt_q    <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err_q  <= 1'b0;

         if (start) begin
            grant_q  <= win;
            pwrite_q <= win ? bus.we1    : bus.we0;
            paddr_q  <= win ? bus.addr1  : bus.addr0;
            pwdata_q <= win ? bus.wdata1 : bus.wdata0;
         end

         case (state_q)
            ACCESS: begin
               if (pwrite_q) begin
                  ack0_q <= ~grant_q;
                  ack1_q <= grant_q;
               end else begin
                  cnt_q <= '0;
               end
            end
            RDWAIT: begin
               if (bus.valid) begin
                  rdata_q <= bus.prdata;
                  ack0_q  <= ~grant_q;
                  ack1_q  <= grant_q;
               end else if (timeout_hit) begin
                  rdata_q <= '1;
                  err_q   <= 1'b1;
                  ack0_q  <= ~grant_q;
                  ack1_q  <= grant_q;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.err     = err_q;
   assign bus.rdata   = rdata_q;
   assign bus.paddr   = paddr_q;
   assign bus.pwrite  = pwrite_q;
   assign bus.pwdata  = pwdata_q;
   assign bus.psel    = psel_c;
   assign bus.penable = penable_c;

endmodule

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
//   Directed bench for apb_arbiter. A small APB memory model answers reads
//   with valid one cycle after ACCESS (can be disabled to force timeouts).
// -----------------------------------------------------------------------------
module tb_apb_arbiter;
   localparam int          AW = 32;
   localparam int          DW = 32;
   localparam int unsigned TO = 4;

   logic clk;
   logic rst;

   apb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem [16];
   logic        slave_en;
   logic        rd_pend;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // APB memory slave: acts on the falling edge, away from the DUT edge.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
      rd_pend    = 1'b0;
      bus.valid  = 1'b0;
      bus.prdata = '0;
      forever begin
         @(negedge clk);
         bus.valid  = rd_pend & slave_en;
         bus.prdata = bus.valid ? mem[bus.paddr[3:0]] : '0;
         rd_pend    = bus.psel & bus.penable & ~bus.pwrite & ~rst;
         if (bus.psel & bus.penable & bus.pwrite)
            mem[bus.paddr[3:0]] = bus.pwdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next ack pulse; port = -1 if none arrives.
   task automatic wait_ack(output int port);
      bit done;
      port = -1;
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         step();
         if (bus.ack0) begin
            port = 0;
            done = 1'b1;
         end else if (bus.ack1) begin
            port = 1;
            done = 1'b1;
         end
      end
   endtask

   int p;
   int acks, setups, first_ack, second_ack;

   initial begin
      rst        = 1'b1;
      slave_en   = 1'b1;
      bus.req0   = 1'b0;
      bus.req1   = 1'b0;
      bus.we0    = 1'b0;
      bus.we1    = 1'b0;
      bus.addr0  = '0;
      bus.addr1  = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
      step();
      step();

      // ---------------- reset state ----------------
      chk("rst_psel",    32'(bus.psel),    0);
      chk("rst_penable", 32'(bus.penable), 0);
      chk("rst_pwrite",  32'(bus.pwrite),  0);
      chk("rst_paddr",   bus.paddr,        0);
      chk("rst_pwdata",  bus.pwdata,       0);
      chk("rst_ack0",    32'(bus.ack0),    0);
      chk("rst_ack1",    32'(bus.ack1),    0);
      chk("rst_err",     32'(bus.err),     0);
      chk("rst_rdata",   bus.rdata,        0);
      rst = 1'b0;
      step();

      // ---------------- port 1 write 0x10 <= DEADBEEF ----------------
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h10; bus.wdata1 = 32'hDEADBEEF;
      step();
      chk("wr_setup_psel",    32'(bus.psel),    1);
      chk("wr_setup_penable", 32'(bus.penable), 0);
      chk("wr_paddr",         bus.paddr,        32'h10);
      chk("wr_pwrite",        32'(bus.pwrite),  1);
      chk("wr_pwdata",        bus.pwdata,       32'hDEADBEEF);
      step();
      chk("wr_access_psel",    32'(bus.psel),    1);
      chk("wr_access_penable", 32'(bus.penable), 1);
      chk("wr_access_noack",   32'(bus.ack1),    0);
      step();
      chk("wr_ack1",        32'(bus.ack1), 1);
      chk("wr_err",         32'(bus.err),  0);
      chk("wr_idle_psel",   32'(bus.psel), 0);
      chk("wr_rdata_keep",  bus.rdata,     0);
      bus.req1 = 1'b0;
      step();
      chk("wr_ack1_pulse", 32'(bus.ack1), 0);

      // ---------------- port 1 read 0x10 ----------------
      bus.req1 = 1'b1; bus.we1 = 1'b0;
      step();
      chk("rd_setup_psel",   32'(bus.psel),   1);
      chk("rd_setup_pwrite", 32'(bus.pwrite), 0);
      step();
      chk("rd_access_penable", 32'(bus.penable), 1);
      step();
      chk("rd_wait_psel",  32'(bus.psel), 0);
      chk("rd_wait_noack", 32'(bus.ack1), 0);
      step();
      chk("rd_ack1",  32'(bus.ack1), 1);
      chk("rd_err",   32'(bus.err),  0);
      chk("rd_rdata", bus.rdata,     32'hDEADBEEF);
      bus.req1 = 1'b0;
      step();
      chk("rd_ack1_pulse", 32'(bus.ack1), 0);

      // ---------------- timeout read on port 0 ----------------
      slave_en = 1'b0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h7;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("to_noack", 32'(bus.ack0), 0);
         if (k >= 3) chk("to_wait_psel", 32'(bus.psel), 0);
      end
      step();
      chk("to_ack0",  32'(bus.ack0), 1);
      chk("to_err",   32'(bus.err),  1);
      chk("to_rdata", bus.rdata,     32'hFFFFFFFF);
      bus.req0 = 1'b0;
      step();
      chk("to_err_clear",  32'(bus.err),  0);
      chk("to_ack0_pulse", 32'(bus.ack0), 0);
      slave_en = 1'b1;

      // ---------------- held req: two writes on port 0 ----------------
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h1; bus.wdata0 = 32'h11;
      acks = 0; setups = 0; first_ack = 0; second_ack = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (bus.psel && !bus.penable) setups++;
         if (bus.ack0) begin
            acks++;
            if (acks == 1) begin
               first_ack  = k;
               bus.addr0  = 32'h2;
               bus.wdata0 = 32'h22;
            end else begin
               second_ack = k;
               bus.req0   = 1'b0;
            end
         end
      end
      chk("held_first_ack",  32'(first_ack),  3);
      chk("held_second_ack", 32'(second_ack), 7);
      chk("held_ack_count",  32'(acks),       2);
      chk("held_setups",     32'(setups),     2);
      chk("held_mem1",       mem[1],          32'h11);
      chk("held_mem2",       mem[2],          32'h22);

      // ---------------- simultaneous reads from reset ----------------
      rst = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h3;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h5;
      step();
      step();
      rst = 1'b0;
`ifdef APB_ARB_RR_EN
      wait_ack(p);
      chk("rr_grant0", 32'(p),    0);
      chk("rr_rdata0", bus.rdata, 32'hA0000003);
      wait_ack(p);
      chk("rr_grant1", 32'(p),    1);
      chk("rr_rdata1", bus.rdata, 32'hA0000005);
      wait_ack(p);
      chk("rr_grant2", 32'(p),    0);
      chk("rr_rdata2", bus.rdata, 32'hA0000003);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
`else
      wait_ack(p);
      chk("fp_grant0", 32'(p),    1);
      chk("fp_rdata0", bus.rdata, 32'hA0000005);
      bus.req1 = 1'b0;
      wait_ack(p);
      chk("fp_grant1", 32'(p),    0);
      chk("fp_rdata1", bus.rdata, 32'hA0000003);
      bus.req0 = 1'b0;
`endif
      step();
      step();
      chk("sim_idle_psel", 32'(bus.psel), 0);

      // ---------------- reset during ACCESS ----------------
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h4; bus.wdata1 = 32'h44;
      step();
      step();
      chk("rm_access_penable", 32'(bus.penable), 1);
      #1 rst = 1'b1;
      #1;
      chk("rm_psel_drop",    32'(bus.psel),    0);
      chk("rm_penable_drop", 32'(bus.penable), 0);
      bus.req1 = 1'b0;
      step();
      chk("rm_noack",   32'(bus.ack1), 0);
      chk("rm_nowrite", mem[4],        32'hA0000004);
      rst = 1'b0;
      step();
      chk("rm_noack_after", 32'(bus.ack1), 0);
      bus.req1 = 1'b1;
      step();
      step();
      step();
      chk("rm_retry_ack1", 32'(bus.ack1), 1);
      bus.req1 = 1'b0;
      step();
      chk("rm_retry_mem4", mem[4], 32'h44);

      // ---------------- early drop during SETUP ----------------
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h5;
      step();
      chk("ed_setup_psel", 32'(bus.psel), 1);
      bus.req1 = 1'b0;
      step();
      step();
      chk("ed_noack_early", 32'(bus.ack1), 0);
      step();
      chk("ed_ack1",  32'(bus.ack1), 1);
      chk("ed_err",   32'(bus.err),  0);
      chk("ed_rdata", bus.rdata,     32'hA0000005);
      step();
      chk("ed_ack1_once", 32'(bus.ack1), 0);
      step();
      chk("ed_idle_psel", 32'(bus.psel), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-port APB master that shares the single APB memory slave between the nanoQuarter instruction-fetch port (port 0) and the load/store port (port 1). Each requester issues a simple req/ack transaction. The block arbitrates between them, sequences the APB SETUP/ACCESS phases, waits for the slave's read `valid`, and returns read data with a one-cycle ack. A read timeout ends with an error flag if the slave never answers.

## Interface
- ADDR_W, 32, address width for requesters and `paddr`
- DATA_W, 32, data width
- TIMEOUT, 4, maximum cycles spent in RDWAIT before an error ack (legal range 1–15)

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  transfer request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = read timed out
- rdata  out  DATA_W  read data, valid with the read ack
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  DATA_W  APB write data
- valid  in  1  slave read-data valid
- prdata  in  DATA_W  slave read data

## Operation
- States: IDLE, SETUP, ACCESS, RDWAIT.
- **IDLE**
  - If any eligible req is high, pick a winner.
  - Register the winner's we/addr/wdata into pwrite/paddr/pwdata.
  - Record the granted port and go to SETUP.
- **SETUP:** psel=1, penable=0. Go to ACCESS.
- **ACCESS:** psel=1, penable=1.
  - Write: go to IDLE and assert ack of the granted port next cycle, with err=0.
  - Read: go to RDWAIT and clear the timeout counter.
- **RDWAIT:** psel=0, penable=0.
  - If valid=1: capture prdata into rdata, pulse ack next cycle with err=0, go to IDLE.
  - Else increment the counter. When the counter reaches TIMEOUT: set rdata=all ones, pulse ack with err=1, go to IDLE.
- Eligibility: a port whose ack is high in the current cycle is not eligible that cycle. A held req is treated as a new request from the following cycle.
- Request fields are sampled only at grant. The requester keeps req high until its ack. A req dropped before ack does not abort the transfer; the ack is still issued.
- Simultaneous requests are resolved by the arbitration policy (see Configuration).
- rdata holds its last value between reads. Write acks leave rdata unchanged.
- Reset outputs: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, ack0=ack1=0, err=0, rdata=0. Reset sets state=IDLE, counter=0, last-grant=1.
- Reset mid-transfer: the transfer is abandoned, no ack is issued, and APB strobes drop immediately.

## Timing
- Request seen in IDLE in cycle T:
  - SETUP in T+1
  - ACCESS in T+2
  - write ack in T+3
  - read ack in T+4 when the slave gives valid in T+3
- Back-to-back from a held req on the same port: next SETUP starts 2 cycles after the ack cycle (the port is ineligible during the ack cycle), giving a write period of 4 cycles.
- Timeout read: ack with err=1 in T+3+TIMEOUT.
- A different port's request can be granted in the ack cycle; its SETUP follows in the next cycle.

## Configuration
- APB_ARB_RR_EN defined: round-robin. On a tie, the port not granted last wins, and last-grant updates on every grant.
- APB_ARB_RR_EN undefined: fixed priority, port 1 (data) always beats port 0. The last-grant register is absent.

## Test plan
- Single write then read: port 1 writes addr 0x10 with data 0xDEADBEEF.
  - Required: ack1 at T+3, psel/penable sequence 10→11.
  - Then a port 1 read of 0x10 returns rdata=0xDEADBEEF, ack1 at T+4, err=0.
- Simultaneous reads: req0 and req1 both high from reset.
  - RR: grants are port 0, port 1, port 0.
  - Fixed: port 1 is served first and port 0 only after req1 drops.
- Timeout: slave valid tied low, port 0 reads, TIMEOUT=4.
  - Required: ack0 with err=1 and rdata=0xFFFFFFFF at T+7.
- Held req: port 0 holds req for 2 writes (addr 1, 2).
  - Required: exactly 2 acks, 4 cycles apart, and no duplicate transfer in the ack cycle.
- Reset mid-ACCESS: assert rst while penable=1.
  - Required: psel/penable=0 immediately, no ack, and a normal transfer after release.
- Early drop: req1 drops during SETUP.
  - Required: the transfer completes and ack1 still pulses once.
